// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared types and helpers for the 1-to-4 demux dispatcher lane.
package demux_ctrl_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
    lane_onehot = NUM_LANES'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_rr_dispatcher_if.sv
// Upstream handshake, downstream lane strobes and drop status of the dispatcher.
interface demux_rr_dispatcher_if #(
  parameter int DATA_W = 8
);
  import demux_ctrl_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [SEL_W-1:0]      in_dest;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [NUM_LANES-1:0]  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic [NUM_LANES-1:0]  out_ready;
  logic                  drop_pulse;
  logic [7:0]            drop_cnt;

  modport master (
    output in_valid, in_data, in_dest, mode, out_ready,
    input  in_ready, sel, out_valid, out_data, drop_pulse, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_dest, mode, out_ready,
    output in_ready, sel, out_valid, out_data, drop_pulse, drop_cnt
  );

endinterface

// File: rtl/demux_rr_dispatcher_wait_timer.sv
// Per-item wait counter: counts stalled SEND cycles and flags the timeout cycle.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = (TIMEOUT != 0) && enable && (cnt_q == LAST);

  // Count stops at LAST so it can never wrap; with timeouts disabled it stays at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Dispatches one upstream item at a time to one of four sinks, round-robin or
// directed, with a stall timeout that rotates (round-robin) or drops (directed).
module demux_rr_dispatcher
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_rr_dispatcher_if.slave  bus
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   tgt_q, tgt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               mode_q, mode_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               drop_pulse_q, drop_pulse_d;

  logic accept, xfer, tmr_en, tmr_clr, expire;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign xfer    = (state_q == SEND) && bus.out_ready[tgt_q];
  assign tmr_en  = (state_q == SEND) && !bus.out_ready[tgt_q];
  assign tmr_clr = accept || expire;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expire (expire)
  );

  assign bus.in_ready   = (state_q == IDLE) && !rst;
  assign bus.out_valid  = (state_q == SEND) ? lane_onehot(tgt_q) : '0;
  assign bus.sel        = tgt_q;
  assign bus.out_data   = data_q;
  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_cnt   = drop_cnt_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    tgt_d        = tgt_q;
    data_d       = data_q;
    mode_d       = mode_q;
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = bus.in_data;
          mode_d  = bus.mode;
          tgt_d   = bus.mode ? bus.in_dest : ptr_q;
          state_d = SEND;
        end
      end
      SEND: begin
        // A ready sink on the timeout cycle still takes the item.
        if (xfer) begin
          state_d = IDLE;
          if (!mode_q) ptr_d = tgt_q + SEL_W'(1);
        end else if (expire) begin
          if (!mode_q) begin
            tgt_d = tgt_q + SEL_W'(1);
          end else begin
            state_d      = IDLE;
            drop_pulse_d = 1'b1;
            drop_cnt_d   = sat_inc8(drop_cnt_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      tgt_q        <= '0;
      data_q       <= '0;
      mode_q       <= 1'b0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tgt_q        <= tgt_d;
      data_q       <= data_d;
      mode_q       <= mode_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

endmodule
